frame_serializer: RTL

- Parallel-load, serial-out word serializer. The counterpart of the serial-in word shift register used for the display/message path.
- Captures a whole frame of WORD_COUNT words in one cycle, then emits them one word at a time over a valid/ready stream.
- The emit order is chosen so that shifting the stream into a serial-in shift register of the same depth rebuilds the original frame layout.

---
 rtl/frame_serializer.sv | 106 ++++++++++
 1 files changed

// File: rtl/frame_serializer.sv
// Parallel-load, serial-out word serializer: captures a whole frame in one cycle and
// streams it highest word first over a valid/ready handshake.
module frame_serializer #(
  parameter  int WORD_COUNT = 21,
  parameter  int WIDTH      = 8,
  localparam int IDX_W      = $clog2(WORD_COUNT)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  output logic                        loadReady,
  input  logic [WORD_COUNT*WIDTH-1:0] frameIn,
  input  logic                        abort,
  output logic [WIDTH-1:0]            wordOut,
  output logic                        wordValid,
  input  logic                        wordReady,
  output logic                        wordLast,
  output logic [IDX_W-1:0]            wordIndex,
  output logic                        busy,
  output logic                        frameDone
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             capture;
  logic [WIDTH-1:0] frameBuf_q [WORD_COUNT];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // The buffer only changes on an accepted load, so it keeps the last frame while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < WORD_COUNT; k++) begin
        frameBuf_q[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < WORD_COUNT; k++) begin
        frameBuf_q[k] <= frameIn[k*WIDTH +: WIDTH];
      end
    end
  end

  // Abort beats a simultaneous transfer: the word leaves, but no completion is reported.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          capture = 1'b1;
          idx_d   = LAST_IDX;
          state_d = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (wordReady) begin
          if (idx_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // wordOut is forced to zero whenever nothing valid is offered.
  always_comb begin
    wordValid = (state_q == SEND);
    busy      = (state_q == SEND);
    loadReady = (state_q == IDLE);
    wordIndex = idx_q;
    wordLast  = (state_q == SEND) && (idx_q == '0);
    wordOut   = (state_q == SEND) ? frameBuf_q[idx_q] : '0;
    frameDone = done_q;
  end

endmodule
